// File: rtl/stream_playback_if.sv
// AXI4 read-address/read-data channels plus the AXI4-Stream output of the playback engine.
interface stream_playback_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 6
) ();
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
               m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid, m_axis_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
               m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid, m_axis_tready
    );
endinterface

// File: rtl/stream_playback.sv
// Replays a DDR buffer as AXI4-Stream; first arvalid two cycles after start is sampled, R beat to tvalid one cycle.
// tready stalls hold tdata/tlast; AR issue is throttled by FIFO credit so rready never drops in normal use.
module stream_playback #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 6,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [31:0]           playback_size,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    stream_playback_if.master     bus
);
    localparam int ALIGN_W    = $clog2(BURST_LEN * KEEP_WIDTH);
    localparam int BEAT_SHIFT = $clog2(KEEP_WIDTH);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  start_q, start_q2;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rem_q, rem_d, size_q, size_d, out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d, fcount_q, fcount_d;
    logic                  arvalid_q, arvalid_d, error_q, error_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic        fifo_full, fifo_empty, r_hs, t_hs, ar_hs, start_edge, credit_ok;
    logic [31:0] next_len, ar_beats;
    logic        unused_rid_rlast;

    assign unused_rid_rlast = ^{bus.m_axi_rid, bus.m_axi_rlast};

    assign fifo_full  = (fcount_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fcount_q == '0);
    assign r_hs       = bus.m_axi_rvalid & bus.m_axi_rready;
    assign t_hs       = ~fifo_empty & bus.m_axis_tready;
    assign ar_hs      = arvalid_q & bus.m_axi_arready;
    assign start_edge = start_q & ~start_q2;
    assign next_len   = (rem_q > 32'(BURST_LEN)) ? 32'(BURST_LEN) : rem_q;
    assign ar_beats   = 32'(arlen_q) + 32'd1;
    // Beats already buffered plus beats still owed by DDR must fit alongside the new burst.
    assign credit_ok  = (32'(fcount_q) + 32'(inflight_q) + next_len) <= 32'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        size_d     = size_q;
        arvalid_d  = arvalid_q;
        arlen_d    = arlen_q;
        error_d    = error_q | (r_hs & (bus.m_axi_rresp != 2'b00));
        out_cnt_d  = out_cnt_q + 32'(t_hs);
        inflight_d = inflight_q + (ar_hs ? CNT_W'(ar_beats) : '0) - CNT_W'(r_hs);
        fcount_d   = fcount_q + CNT_W'(r_hs) - CNT_W'(t_hs);
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    addr_d    = {start_addr[ADDR_WIDTH-1:ALIGN_W], {ALIGN_W{1'b0}}};
                    size_d    = playback_size;
                    rem_d     = playback_size;
                    out_cnt_d = '0;
                    error_d   = 1'b0;
                    state_d   = (playback_size == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (arvalid_q) begin
                    if (bus.m_axi_arready) begin
                        arvalid_d = 1'b0;
                        addr_d    = addr_q + ADDR_WIDTH'(ar_beats << BEAT_SHIFT);
                        rem_d     = rem_q - ar_beats;
                        if (rem_q == ar_beats) state_d = S_DRAIN;
                    end
                end else if (rem_q != 32'd0 && credit_ok) begin
                    arvalid_d = 1'b1;
                    arlen_d   = 8'(next_len - 32'd1);
                end
            end
            S_DRAIN: begin
                if (t_hs && out_cnt_q == size_q - 32'd1) state_d = S_DONE;
            end
            S_DONE: begin
                if (!start_q2) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            start_q2   <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            size_q     <= '0;
            out_cnt_q  <= '0;
            inflight_q <= '0;
            fcount_q   <= '0;
            arvalid_q  <= 1'b0;
            arlen_q    <= '0;
            error_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            start_q2   <= start_q;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            size_q     <= size_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            fcount_q   <= fcount_d;
            arvalid_q  <= arvalid_d;
            arlen_q    <= arlen_d;
            error_q    <= error_d;
            if (r_hs) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (t_hs) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (r_hs) mem[wr_ptr_q] <= bus.m_axi_rdata;
    end

    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = 3'(BEAT_SHIFT);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0000;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = m_axi_aresetn & ~fifo_full;
    assign bus.m_axis_tdata  = mem[rd_ptr_q];
    assign bus.m_axis_tkeep  = '1;
    assign bus.m_axis_tlast  = (out_cnt_q == size_q - 32'd1);
    assign bus.m_axis_tvalid = ~fifo_empty;

    assign o_busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_done  = (state_q == S_DONE);
    assign o_error = error_q;
endmodule

// File: tb/tb_stream_playback.sv
module tb_stream_playback;
    localparam int DW = 512;
    localparam int AW = 34;
    localparam int IW = 6;
    localparam int KW = DW / 8;
    localparam logic [KW-1:0] KEEP_ONES = '1;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [31:0]   playback_size = '0;
    logic          busy, done, error;

    always #5 clk = ~clk;

    stream_playback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    stream_playback dut (
        .m_axi_aclk(clk), .m_axi_aresetn(aresetn), .start(start), .start_addr(start_addr),
        .playback_size(playback_size), .o_busy(busy), .o_done(done), .o_error(error), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        logic [31:0] w;
        w = a[31:0] ^ 32'h5A5A_0000;
        return {(DW/32){w}};
    endfunction

    // Reference model: a buffer at base replays as beats base+64*i; bursts of up to 16 beats.
    logic [AW-1:0] exp_base;
    int exp_size, exp_nb, ar_idx, out_idx, tlast_cnt;
    bit arvalid_seen;
    logic [AW-1:0] ar_log_addr[$];
    int ar_log_len[$];

    task automatic start_run(input logic [AW-1:0] addr, input int size);
        exp_base  = addr & ~AW'(1023);
        exp_size  = size;
        exp_nb    = (size + 15) / 16;
        ar_idx    = 0;
        out_idx   = 0;
        tlast_cnt = 0;
        r_cnt     = 0;
        ar_cnt    = 0;
        ar_log_addr.delete();
        ar_log_len.delete();
        start_addr    = addr;
        playback_size = size;
        start         = 1'b1;
    endtask

    // Memory / sink responder
    typedef struct { logic [AW-1:0] addr; int len; } burst_t;
    burst_t bq[$];
    int beat = 0, r_cnt = 0, ar_cnt = 0, arready_block = 0, err_beat = -1;
    bit tready_en = 1'b1, tready_rand = 1'b0;

    initial begin
        bit ar_hs, r_hs;
        burst_t nb;
        bus.m_axi_arready = 1'b1; bus.m_axi_rid = '0; bus.m_axi_rdata = '0;
        bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            ar_hs   = bus.m_axi_arvalid && bus.m_axi_arready;
            r_hs    = bus.m_axi_rvalid && bus.m_axi_rready;
            nb.addr = bus.m_axi_araddr;
            nb.len  = int'(bus.m_axi_arlen);
            @(posedge clk); #1;
            if (!aresetn) begin
                bq.delete(); beat = 0;
                bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_arready = 1'b1;
                continue;
            end
            if (ar_hs) begin bq.push_back(nb); ar_cnt++; end
            if (r_hs) begin
                r_cnt++; beat++;
                if (beat > bq[0].len) begin void'(bq.pop_front()); beat = 0; end
            end
            if (arready_block > 0) begin
                bus.m_axi_arready = 1'b0;
                if (bus.m_axi_arvalid) arready_block--;
            end else bus.m_axi_arready = 1'b1;
            if (bq.size() > 0) begin
                bus.m_axi_rvalid = 1'b1;
                bus.m_axi_rdata  = beat_data(bq[0].addr + AW'(beat * 64));
                bus.m_axi_rlast  = (beat == bq[0].len);
                bus.m_axi_rresp  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
            end else begin
                bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
            end
            bus.m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : tready_en;
        end
    end

    // Compare process
    initial begin
        bit have_prev = 0, p_arv, p_arr, p_tv, p_tr, p_tl;
        logic [AW-1:0] p_addr;
        logic [7:0] p_len;
        logic [DW-1:0] p_data;
        int el;
        forever begin
            @(negedge clk);
            if (!aresetn) begin have_prev = 0; continue; end
            if (bus.m_axi_arvalid) arvalid_seen = 1'b1;
            if (have_prev && bus.m_axi_arvalid && p_arv && !p_arr) begin
                check("ar_addr_stable", bus.m_axi_araddr, p_addr);
                check("ar_len_stable", bus.m_axi_arlen, p_len);
            end
            if (have_prev && bus.m_axis_tvalid && p_tv && !p_tr) begin
                check("tdata_stable", bus.m_axis_tdata, p_data);
                check("tlast_stable", bus.m_axis_tlast, p_tl);
            end
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                el = exp_size - 16 * ar_idx;
                if (el > 16) el = 16;
                check("ar_extra", ar_idx < exp_nb, 1);
                check("araddr", bus.m_axi_araddr, exp_base + AW'(ar_idx * 1024));
                check("arlen", bus.m_axi_arlen, el - 1);
                ar_log_addr.push_back(bus.m_axi_araddr);
                ar_log_len.push_back(int'(bus.m_axi_arlen));
                ar_idx++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                check("beat_extra", out_idx < exp_size, 1);
                check("tdata", bus.m_axis_tdata, beat_data(exp_base + AW'(out_idx * 64)));
                check("tlast", bus.m_axis_tlast, out_idx == exp_size - 1);
                if (bus.m_axis_tlast) tlast_cnt++;
                out_idx++;
            end
            have_prev = 1; p_arv = bus.m_axi_arvalid; p_arr = bus.m_axi_arready;
            p_addr = bus.m_axi_araddr; p_len = bus.m_axi_arlen;
            p_tv = bus.m_axis_tvalid; p_tr = bus.m_axis_tready;
            p_data = bus.m_axis_tdata; p_tl = bus.m_axis_tlast;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin tick(1); n++; end
        check("done_reached", done, 1);
    endtask

    task automatic finish_run();
        check("beat_count", out_idx, exp_size);
        check("ar_count", ar_idx, exp_nb);
        check("tlast_count", tlast_cnt, (exp_size > 0) ? 1 : 0);
        check("busy_at_done", busy, 0);
        start = 1'b0;
        begin
            int n = 0;
            while (done && n < 10) begin tick(1); n++; end
        end
        check("done_cleared", done, 0);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_arvalid", bus.m_axi_arvalid, 0);
        check("rst_rready", bus.m_axi_rready, 0);
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        #24 aresetn = 1'b1;
        tick(2);

        // 1: 40 beats, pinned latency and burst list
        start_run(34'h1000, 40);
        tick(1);
        check("lat_busy_k", busy, 0);
        tick(1);
        check("lat_busy_k1", busy, 1);
        check("lat_arv_k1", bus.m_axi_arvalid, 0);
        tick(1);
        check("lat_arv_k2", bus.m_axi_arvalid, 1);
        check("arsize", bus.m_axi_arsize, 6);
        check("arburst", bus.m_axi_arburst, 1);
        wait_done(2000);
        check("t1_ar0_addr", ar_log_addr[0], 34'h1000);
        check("t1_ar0_len", ar_log_len[0], 15);
        check("t1_ar1_addr", ar_log_addr[1], 34'h1400);
        check("t1_ar1_len", ar_log_len[1], 15);
        check("t1_ar2_addr", ar_log_addr[2], 34'h1800);
        check("t1_ar2_len", ar_log_len[2], 7);
        check("tkeep", bus.m_axis_tkeep, KEEP_ONES);
        finish_run();

        // 2: zero-length playback
        arvalid_seen = 1'b0;
        start_run(34'h4000, 0);
        tick(3);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_no_ar", arvalid_seen, 0);
        finish_run();

        // 3: stalled sink, credit limits outstanding data
        tready_en = 1'b0;
        start_run(34'h10000, 64);
        tick(200);
        check("stall_r_beats", r_cnt, 32);
        check("stall_ar_cnt", ar_cnt, 2);
        check("stall_out", out_idx, 0);
        tready_en = 1'b1;
        wait_done(2000);
        check("stall_r_total", r_cnt, 64);
        finish_run();

        // 4: error response on beat 5, unaligned start address, random tready
        err_beat = 5;
        tready_rand = 1'b1;
        start_run(34'h2345, 16);
        wait_done(2000);
        check("t4_ar0_addr", ar_log_addr[0], 34'h2000);
        check("err_set", error, 1);
        finish_run();
        check("err_sticky", error, 1);
        err_beat = -1;
        tready_rand = 1'b0;
        start_run(34'h3000, 8);
        tick(3);
        check("err_cleared", error, 0);
        wait_done(2000);
        finish_run();

        // 5: arready held off, second start edge mid-run ignored
        arready_block = 10;
        start_run(34'h8000, 40);
        tick(5);
        start = 1'b0;
        tick(2);
        start = 1'b1;
        wait_done(2000);
        check("blk_ar_cnt", ar_cnt, 3);
        finish_run();

        // 6: reset mid-playback, then replay from start
        start_run(34'h1000, 40);
        begin
            int n = 0;
            while (out_idx < 20 && n < 500) begin tick(1); n++; end
        end
        check("rst_mid_reached", out_idx, 20);
        #1 aresetn = 1'b0;
        #1;
        check("mid_arvalid", bus.m_axi_arvalid, 0);
        check("mid_tvalid", bus.m_axis_tvalid, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_rready", bus.m_axi_rready, 0);
        start = 1'b0;
        tick(3);
        @(negedge clk) aresetn = 1'b1;
        tick(2);
        start_run(34'h1000, 40);
        wait_done(2000);
        finish_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
